load_store_queue: RTL
=====================

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 Parameter ADDR_BITS, default 4, queue depth DEPTH = 2^ADDR_BITS entries.
REQ-002 Parameter MEM_BYTES, default 1, bytes per memory beat; legal values 1, 2, 4.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Port rdy  in  1  global enable; when low, all state holds except reset.
REQ-006 Ports issue_valid in 1, issue_optype in OPCODE_TYPE, issue_rob_id in ROB_ID_RANGE, issue_qi/issue_qj in ROB_ID_RANGE, issue_vi/issue_vj/issue_imm in 32  new entry from dispatcher.
REQ-007 Port lsq_full  out  1  high when count == DEPTH.
REQ-008 Ports commit_valid in 1, commit_rob_id in ROB_ID_RANGE  ROB head commit notification.
REQ-009 Port rollback  in  1  flush of speculative state.
REQ-010 Ports mem_en out 1, mem_wr out 1, mem_addr out 32, mem_wdata out 8*MEM_BYTES, mem_done in 1, mem_rdata in 8*MEM_BYTES  memory controller beat handshake.
REQ-011 Ports alu_valid in 1, alu_rob_id in ROB_ID_RANGE, alu_result in 32  ALU CDB.
REQ-012 Ports lsq_valid out 1, lsq_rob_id out ROB_ID_RANGE, lsq_result out 32  load result CDB.

Function
REQ-013 Queue SHALL be a circular FIFO with head, tail, and count; all DEPTH entries usable; pointers wrap DEPTH-1 -> 0.
REQ-014 Issue SHALL be accepted when issue_valid && !lsq_full (lsq_full sampled at cycle start, regardless of a same-cycle dequeue).
REQ-015 An operand tag equal to RENAMED_ZERO SHALL mean ready; issue_qi/issue_qj matching alu_rob_id or lsq_rob_id in the same cycle SHALL be stored as ready with the bypassed value.
REQ-016 Each cycle, every valid entry whose Qi/Qj matches an asserted CDB tag (ALU or own load result) SHALL capture the value and clear the tag; invalid entries SHALL be left untouched.
REQ-017 Head SHALL start when valid, both tags ready, FSM in IDLE, and (for loads) unconditionally, or (for stores) a commit has been seen for its rob_id: commit_valid && commit_rob_id == head rob_id, either in the same cycle or latched earlier per entry.
REQ-018 FSM states: IDLE, LOAD, STORE; on start: dequeue head, address = vi + imm, nbeats = ceil(size/MEM_BYTES), mem_en=1 with beat 0 on next cycle.
REQ-019 Sizes: B=1, H=2, W=4 bytes; byte k of the access SHALL be at address+k, little-endian.
REQ-020 Each mem_done SHALL complete one beat: address += MEM_BYTES, next write bytes driven, read bytes placed at lane offset; mem_en deasserts on the edge completing the last beat.
REQ-021 LOAD last beat SHALL, on the same edge, return FSM to IDLE and assert lsq_valid for exactly one cycle with result sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-022 STORE last beat SHALL return FSM to IDLE with no CDB output.
REQ-023 Back-to-back: a new head may start the cycle after FSM re-enters IDLE.

Reset
REQ-024 rst low SHALL immediately clear head, tail, count, all entry valid/commit bits, FSM to IDLE, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, lsq_valid=0, lsq_rob_id=0, lsq_result=0, lsq_full=0.
REQ-025 rollback SHALL on the next edge invalidate all queued entries, abort a LOAD (mem_en=0, no lsq_valid), and suppress any same-cycle issue.
REQ-026 A STORE in progress at rollback SHALL complete all beats (committed state is not speculative); new heads start only after it finishes.
REQ-027 rst asserted mid-transaction SHALL abort regardless of type.

Verification
REQ-028 MEM_BYTES=1: LW, vi=0x100, imm=4, bytes 0x78,0x56,0x34,0x12 -> 4 beats at 0x104..0x107, lsq_valid one cycle, lsq_result=0x12345678.
REQ-029 MEM_BYTES=4: LB reading byte 0x80 -> one beat, lsq_result=0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 SW with qi pending tag 5, alu_valid tag 5 result 0x200, then commit_valid for SW -> store starts only after commit, mem_addr=0x200+imm, mem_wr=1.
REQ-031 Fill DEPTH=16 entries without draining -> lsq_full=1 after 16th, 17th issue ignored, tail wraps to 0.
REQ-032 Rollback during second beat of SH and during LW -> SH finishes both beats; LW aborted, no lsq_valid, queue empty afterwards.
REQ-033 Load result tag 3 broadcast while dependent SW enqueued with qj=3 same cycle -> entry captures value via bypass.

Source files
------------

// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
// Module : load_store_queue
// Brief  : In-order load/store queue with operand wakeup, commit-gated stores
//          and a beat-serialised memory port.
// Rev    : 1.0  initial release
// ============================================================================
module load_store_queue #(
    parameter int ADDR_BITS = 4,
    parameter int MEM_BYTES = 1,
    parameter int ROB_BITS  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   issue_valid,
    input  logic [2:0]             issue_optype,
    input  logic [ROB_BITS-1:0]    issue_rob_id,
    input  logic [ROB_BITS-1:0]    issue_qi,
    input  logic [ROB_BITS-1:0]    issue_qj,
    input  logic [31:0]            issue_vi,
    input  logic [31:0]            issue_vj,
    input  logic [31:0]            issue_imm,
    output logic                   lsq_full,
    input  logic                   commit_valid,
    input  logic [ROB_BITS-1:0]    commit_rob_id,
    input  logic                   rollback,
    output logic                   mem_en,
    output logic                   mem_wr,
    output logic [31:0]            mem_addr,
    output logic [8*MEM_BYTES-1:0] mem_wdata,
    input  logic                   mem_done,
    input  logic [8*MEM_BYTES-1:0] mem_rdata,
    input  logic                   alu_valid,
    input  logic [ROB_BITS-1:0]    alu_rob_id,
    input  logic [31:0]            alu_result,
    output logic                   lsq_valid,
    output logic [ROB_BITS-1:0]    lsq_rob_id,
    output logic [31:0]            lsq_result
);

    localparam int                    c_DEPTH        = 1 << ADDR_BITS;
    localparam int                    c_BEAT_W       = 8 * MEM_BYTES;
    localparam logic [ROB_BITS-1:0]   c_RENAMED_ZERO = '0;
    localparam logic [ADDR_BITS-1:0]  c_PTR_ONE      = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]    c_CNT_ONE      = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0]    c_CNT_FULL     = (ADDR_BITS+1)'(c_DEPTH);
    localparam logic [2:0]            c_NB_H         = 3'((2 + MEM_BYTES - 1) / MEM_BYTES);
    localparam logic [2:0]            c_NB_W         = 3'((4 + MEM_BYTES - 1) / MEM_BYTES);

    localparam logic [2:0] c_OP_LB  = 3'd0;
    localparam logic [2:0] c_OP_LH  = 3'd1;
    localparam logic [2:0] c_OP_LW  = 3'd2;
    localparam logic [2:0] c_OP_LBU = 3'd3;
    localparam logic [2:0] c_OP_LHU = 3'd4;
    localparam logic [2:0] c_OP_SB  = 3'd5;
    localparam logic [2:0] c_OP_SH  = 3'd6;
    localparam logic [2:0] c_OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    logic [c_DEPTH-1:0]   r_valid;
    logic [c_DEPTH-1:0]   r_committed;
    logic [2:0]           r_op  [c_DEPTH];
    logic [ROB_BITS-1:0]  r_rob [c_DEPTH];
    logic [ROB_BITS-1:0]  r_qi  [c_DEPTH];
    logic [ROB_BITS-1:0]  r_qj  [c_DEPTH];
    logic [31:0]          r_vi  [c_DEPTH];
    logic [31:0]          r_vj  [c_DEPTH];
    logic [31:0]          r_imm [c_DEPTH];
    logic [ADDR_BITS-1:0] r_head;
    logic [ADDR_BITS-1:0] r_tail;
    logic [ADDR_BITS:0]   r_count;

    state_t               r_state;
    logic [2:0]           r_cur_op;
    logic [ROB_BITS-1:0]  r_cur_rob;
    logic [2:0]           r_beat;
    logic [2:0]           r_nbeats;
    logic [31:0]          r_wd;
    logic [31:0]          r_rd;

    logic                 w_push;
    logic                 w_start;
    logic [ROB_BITS-1:0]  w_in_qi;
    logic [ROB_BITS-1:0]  w_in_qj;
    logic [31:0]          w_in_vi;
    logic [31:0]          w_in_vj;
    logic [2:0]           w_h_op;
    logic                 w_h_store;
    logic                 w_h_commit;
    logic [2:0]           w_h_nbeats;
    logic [31:0]          w_h_sdata;
    logic [31:0]          w_h_addr;
    logic [31:0]          w_wshift;
    logic [31:0]          w_rshift;
    logic [c_BEAT_W-1:0]  w_next_wdata;
    logic [31:0]          w_rd_merged;
    logic                 w_last;
    logic [31:0]          w_load_ext;

    assign lsq_full = (r_count == c_CNT_FULL);
    assign w_push   = issue_valid && !lsq_full && !rollback;

    // Operands arriving on either CDB in the issue cycle are captured directly.
    always_comb begin
        w_in_qi = issue_qi;
        w_in_vi = issue_vi;
        w_in_qj = issue_qj;
        w_in_vj = issue_vj;
        if (issue_qi != c_RENAMED_ZERO) begin
            if (alu_valid && issue_qi == alu_rob_id) begin
                w_in_qi = c_RENAMED_ZERO;
                w_in_vi = alu_result;
            end else if (lsq_valid && issue_qi == lsq_rob_id) begin
                w_in_qi = c_RENAMED_ZERO;
                w_in_vi = lsq_result;
            end
        end
        if (issue_qj != c_RENAMED_ZERO) begin
            if (alu_valid && issue_qj == alu_rob_id) begin
                w_in_qj = c_RENAMED_ZERO;
                w_in_vj = alu_result;
            end else if (lsq_valid && issue_qj == lsq_rob_id) begin
                w_in_qj = c_RENAMED_ZERO;
                w_in_vj = lsq_result;
            end
        end
    end

    always_comb begin
        w_h_op     = r_op[r_head];
        w_h_store  = (w_h_op == c_OP_SB) || (w_h_op == c_OP_SH) || (w_h_op == c_OP_SW);
        w_h_commit = r_committed[r_head] || (commit_valid && commit_rob_id == r_rob[r_head]);
        w_start    = (r_state == ST_IDLE) && r_valid[r_head] && !rollback &&
                     (r_qi[r_head] == c_RENAMED_ZERO) && (r_qj[r_head] == c_RENAMED_ZERO) &&
                     (!w_h_store || w_h_commit);
        w_h_addr   = r_vi[r_head] + r_imm[r_head];
        w_h_nbeats = c_NB_W;
        w_h_sdata  = r_vj[r_head];
        case (w_h_op)
            c_OP_LB, c_OP_LBU, c_OP_SB: begin
                w_h_nbeats = 3'd1;
                w_h_sdata  = {24'd0, r_vj[r_head][7:0]};
            end
            c_OP_LH, c_OP_LHU, c_OP_SH: begin
                w_h_nbeats = c_NB_H;
                w_h_sdata  = {16'd0, r_vj[r_head][15:0]};
            end
            default: ;
        endcase
    end

    // Beat b of an access occupies bits [b*c_BEAT_W +: c_BEAT_W] of the 32-bit word.
    always_comb begin
        w_wshift     = ({29'd0, r_beat} + 32'd1) * 32'(c_BEAT_W);
        w_rshift     = {29'd0, r_beat} * 32'(c_BEAT_W);
        w_next_wdata = c_BEAT_W'(r_wd >> w_wshift);
        w_rd_merged  = r_rd | 32'(64'(mem_rdata) << w_rshift);
        w_last       = (r_beat == r_nbeats - 3'd1);
        case (r_cur_op)
            c_OP_LB:  w_load_ext = {{24{w_rd_merged[7]}}, w_rd_merged[7:0]};
            c_OP_LBU: w_load_ext = {24'd0, w_rd_merged[7:0]};
            c_OP_LH:  w_load_ext = {{16{w_rd_merged[15]}}, w_rd_merged[15:0]};
            c_OP_LHU: w_load_ext = {16'd0, w_rd_merged[15:0]};
            default:  w_load_ext = w_rd_merged;
        endcase
    end

    // Entry payload: operand wakeup and issue writes (gated by the valid bits).
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (r_valid[i] && r_qi[i] != c_RENAMED_ZERO) begin
                    if (alu_valid && r_qi[i] == alu_rob_id) begin
                        r_qi[i] <= c_RENAMED_ZERO;
                        r_vi[i] <= alu_result;
                    end else if (lsq_valid && r_qi[i] == lsq_rob_id) begin
                        r_qi[i] <= c_RENAMED_ZERO;
                        r_vi[i] <= lsq_result;
                    end
                end
                if (r_valid[i] && r_qj[i] != c_RENAMED_ZERO) begin
                    if (alu_valid && r_qj[i] == alu_rob_id) begin
                        r_qj[i] <= c_RENAMED_ZERO;
                        r_vj[i] <= alu_result;
                    end else if (lsq_valid && r_qj[i] == lsq_rob_id) begin
                        r_qj[i] <= c_RENAMED_ZERO;
                        r_vj[i] <= lsq_result;
                    end
                end
            end
            if (w_push) begin
                r_op[r_tail]  <= issue_optype;
                r_rob[r_tail] <= issue_rob_id;
                r_qi[r_tail]  <= w_in_qi;
                r_qj[r_tail]  <= w_in_qj;
                r_vi[r_tail]  <= w_in_vi;
                r_vj[r_tail]  <= w_in_vj;
                r_imm[r_tail] <= issue_imm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= '0;
            r_committed <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_state     <= ST_IDLE;
            r_cur_op    <= '0;
            r_cur_rob   <= '0;
            r_beat      <= '0;
            r_nbeats    <= '0;
            r_wd        <= '0;
            r_rd        <= '0;
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            lsq_valid   <= 1'b0;
            lsq_rob_id  <= '0;
            lsq_result  <= '0;
        end else if (rdy) begin
            lsq_valid <= 1'b0;

            for (int i = 0; i < c_DEPTH; i++) begin
                if (r_valid[i] && commit_valid && commit_rob_id == r_rob[i]) begin
                    r_committed[i] <= 1'b1;
                end
            end
            if (w_start) begin
                r_valid[r_head]     <= 1'b0;
                r_committed[r_head] <= 1'b0;
                r_head              <= r_head + c_PTR_ONE;
            end
            if (w_push) begin
                r_valid[r_tail]     <= 1'b1;
                r_committed[r_tail] <= 1'b0;
                r_tail              <= r_tail + c_PTR_ONE;
            end
            case ({w_push, w_start})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: ;
            endcase
            if (rollback) begin
                r_valid     <= '0;
                r_committed <= '0;
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= w_h_store ? ST_STORE : ST_LOAD;
                        r_cur_op  <= w_h_op;
                        r_cur_rob <= r_rob[r_head];
                        r_beat    <= 3'd0;
                        r_nbeats  <= w_h_nbeats;
                        r_wd      <= w_h_sdata;
                        r_rd      <= '0;
                        mem_en    <= 1'b1;
                        mem_wr    <= w_h_store;
                        mem_addr  <= w_h_addr;
                        mem_wdata <= c_BEAT_W'(w_h_sdata);
                    end
                end
                ST_LOAD: begin
                    if (rollback) begin
                        r_state <= ST_IDLE;
                        mem_en  <= 1'b0;
                    end else if (mem_done) begin
                        r_rd <= w_rd_merged;
                        if (w_last) begin
                            r_state    <= ST_IDLE;
                            mem_en     <= 1'b0;
                            lsq_valid  <= 1'b1;
                            lsq_rob_id <= r_cur_rob;
                            lsq_result <= w_load_ext;
                        end else begin
                            r_beat   <= r_beat + 3'd1;
                            mem_addr <= mem_addr + 32'(MEM_BYTES);
                        end
                    end
                end
                ST_STORE: begin
                    // Committed stores always run to completion, rollback or not.
                    if (mem_done) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            mem_en  <= 1'b0;
                            mem_wr  <= 1'b0;
                        end else begin
                            r_beat    <= r_beat + 3'd1;
                            mem_addr  <= mem_addr + 32'(MEM_BYTES);
                            mem_wdata <= w_next_wdata;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
